// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the programmable-threshold FIFO.
// Pure declarations; no logic.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic al_full;
        logic al_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Purpose: DEPTH x WIDTH storage, one write port, one synchronous read port owning rdata.
// Latency: read data appears on the edge after the read request; write lands on its edge.
// Backpressure: none; the caller gates requests with full/empty.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_vld,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_vld,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    always_ff @(posedge i_clk) begin
        if (i_wr_vld) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Holds its value between reads; only reset clears it, flush does not.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_dat <= '0;
        end else if (i_rd_vld) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/d1fifo_prog.sv
// Purpose: single-clock FIFO with runtime almost-full/empty thresholds, flush, sticky errors (D1FIFO_ERR_EN).
// Latency: pop accepted at edge t gives rdata/valid after t; push-to-data minimum 2 edges, no bypass.
// Backpressure: push ignored while full, pop ignored while empty; one push and one pop per cycle sustained.
module d1fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    input  logic [CW-1:0]    af_lvl,
    input  logic [CW-1:0]    ae_lvl,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             al_full,
    output logic             al_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = ptr_w(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    fifo_status_t  w_status;
    logic          w_push_acc;
    logic          w_pop_acc;

    always_comb begin
        w_status          = '0;
        w_status.full     = (r_count == CW'(DEPTH));
        w_status.empty    = (r_count == '0);
        w_status.al_full  = (r_count >= af_lvl);
        w_status.al_empty = (r_count <= ae_lvl);
    end

    assign w_push_acc = push && !w_status.full  && !flush;
    assign w_pop_acc  = pop  && !w_status.empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push_acc) r_wptr <= r_wptr + AW'(1);
            if (w_pop_acc)  r_rptr <= r_rptr + AW'(1);
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_valid <= w_pop_acc;
        end
    end

`ifdef D1FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && w_status.full)  r_overflow  <= 1'b1;
            if (pop  && w_status.empty) r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_vld  (w_push_acc),
        .i_wr_addr (r_wptr),
        .i_wr_dat  (wdata),
        .i_rd_vld  (w_pop_acc),
        .i_rd_addr (r_rptr),
        .o_rd_dat  (rdata)
    );

    assign count    = r_count;
    assign valid    = r_valid;
    assign full     = w_status.full;
    assign empty    = w_status.empty;
    assign al_full  = w_status.al_full;
    assign al_empty = w_status.al_empty;

endmodule

// File: tb/tb_d1fifo_prog.sv
// Directed vectors for d1fifo_prog: fill/drain, wrap, simultaneous ops, flush, errors, reset.
module tb_d1fifo_prog;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int CW    = 6;
`ifdef D1FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, flush, push, pop;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             valid;
    logic [CW-1:0]    af_lvl, ae_lvl;
    logic [CW-1:0]    count;
    logic             full, empty, al_full, al_empty, overflow, underflow;

    int n_chk  = 0;
    int n_fail = 0;

    d1fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .wdata     (wdata),
        .pop       (pop),
        .rdata     (rdata),
        .valid     (valid),
        .af_lvl    (af_lvl),
        .ae_lvl    (ae_lvl),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .al_full   (al_full),
        .al_empty  (al_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic        flush;
        logic [15:0] wdata;
        int          exp_count;
        logic        exp_empty;
        logic        exp_valid;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            push = 1'b1; pop = 1'b0; wdata = WIDTH'(base + i);
            step();
        end
        idle();
    endtask

    task automatic pop_chk(input int n, input int base, input string tag);
        for (int i = 0; i < n; i++) begin
            push = 1'b0; pop = 1'b1;
            step();
            chk({tag, "_valid"}, valid, 1);
            chk({tag, "_rdata"}, rdata, base + i);
        end
        idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_al_empty"}, al_empty, 1);
        chk({tag, "_al_full"}, al_full, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_underflow"}, underflow, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0A01, 1, 1'b0, 1'b0, 16'd219};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b1, 16'h0A01};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0A01};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0A02, 1, 1'b0, 1'b0, 16'h0A01};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b1, 16'h0A02};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 16'h0A03, 0, 1'b1, 1'b0, 16'h0A02};

        rst_n = 1'b0; idle(); wdata = '0; af_lvl = 6'd28; ae_lvl = 6'd4;
        step(); step();
        rst_n = 1'b1;
        chk_reset_vals("reset");

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; wdata = WIDTH'(i);
            step();
            chk("fill_count", count, i + 1);
            chk("fill_al_full", al_full, (i + 1) >= 28);
            chk("fill_full", full, (i + 1) == DEPTH);
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            pop = 1'b1;
            step();
            chk("drain_valid", valid, 1);
            chk("drain_rdata", rdata, i);
            chk("drain_count", count, DEPTH - 1 - i);
        end
        idle();
        step();
        chk("drain_empty", empty, 1);
        chk("drain_valid_end", valid, 0);
        chk("drain_rdata_hold", rdata, 31);

        // Wrap-around
        push_n(20, 100);
        pop_chk(20, 100, "wrap1");
        push_n(20, 200);
        chk("wrap_count20", count, 20);
        pop_chk(20, 200, "wrap2");
        chk("wrap_count0", count, 0);

        // Empty-state corners from the vector table
        for (int i = 0; i < 6; i++) begin
            push = tbl[i].push; pop = tbl[i].pop; flush = tbl[i].flush; wdata = tbl[i].wdata;
            step();
            chk($sformatf("vec%0d_count", i), count, tbl[i].exp_count);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].exp_empty);
            chk($sformatf("vec%0d_valid", i), valid, tbl[i].exp_valid);
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
        end
        idle();

        // Simultaneous push+pop at count 10
        push_n(10, 300);
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; pop = 1'b1; wdata = WIDTH'(310 + i);
            step();
            chk("mid_count", count, 10);
            chk("mid_valid", valid, 1);
            chk("mid_rdata", rdata, 300 + i);
        end
        idle();
        pop_chk(10, 305, "mid_tail");
        chk("mid_count0", count, 0);

        // Simultaneous push+pop at full: write dropped
        push_n(DEPTH, 400);
        chk("full_flag", full, 1);
        push = 1'b1; pop = 1'b1; wdata = 16'hDEAD;
        step();
        idle();
        chk("full_pp_count", count, 31);
        chk("full_pp_rdata", rdata, 400);
        pop_chk(31, 401, "full_tail");
        chk("full_tail_empty", empty, 1);

        // Thresholds act combinationally, then flush with push+pop
        push_n(17, 500);
        ae_lvl = 6'd17; #1; chk("thr_ae17", al_empty, 1);
        ae_lvl = 6'd16; #1; chk("thr_ae16", al_empty, 0);
        af_lvl = 6'd17; #1; chk("thr_af17", al_full, 1);
        af_lvl = 6'd18; #1; chk("thr_af18", al_full, 0);
        af_lvl = 6'd28; ae_lvl = 6'd4;
        flush = 1'b1; push = 1'b1; pop = 1'b1; wdata = 16'hBEEF;
        step();
        idle();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_valid", valid, 0);
        chk("flush_rdata_hold", rdata, 431);
        push_n(1, 16'h600);
        pop_chk(1, 16'h600, "post_flush");

        // Sticky error flags
        push_n(DEPTH, 800);
        push = 1'b1; wdata = 16'h1234;
        step();
        idle();
        chk("ovf_set", overflow, ERR_EN);
        step();
        chk("ovf_sticky", overflow, ERR_EN);
        chk("ovf_count", count, 32);
        flush = 1'b1;
        step();
        idle();
        chk("ovf_flush", overflow, 0);
        pop = 1'b1;
        step();
        idle();
        chk("unf_set", underflow, ERR_EN);
        chk("unf_valid", valid, 0);
        step();
        chk("unf_sticky", underflow, ERR_EN);
        flush = 1'b1;
        step();
        idle();
        chk("unf_flush", underflow, 0);
        chk("ovf_after_flush", overflow, 0);

        // Reset mid-stream
        push_n(9, 900);
        chk("pre_rst_count", count, 9);
        pop = 1'b1;
        step();
        idle();
        chk("pre_rst_rdata", rdata, 900);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_vals("midrst");
        push_n(1, 16'h700);
        pop_chk(1, 16'h700, "post_rst");
        pop = 1'b1;
        step();
        idle();
        chk("post_rst_nostale_valid", valid, 0);
        chk("post_rst_nostale_rdata", rdata, 16'h700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
